// File: rtl/fifo_reader_pkg.sv
// Shared types for the fifo_reader burst consumer and its output buffer.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BURST     = 2'd1,
    ST_FLUSH_OUT = 2'd2,
    ST_FINISH    = 2'd3
  } state_e;

  // Output skid buffer: two entries allow a full word per cycle with registered pops.
  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned BUF_CNT_W = $clog2(BUF_DEPTH + 1);

  // Pointer width that never collapses to zero bits for tiny depths.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo.sv
// Show-ahead synchronous FIFO with flush, clock enable and occupancy count.
module fifo
  import fifo_reader_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEPTH         = 2,
  parameter bit          FLOPS_NOT_MEM = 1'b1,
  localparam int unsigned CNT_W        = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W        = ptr_width(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cg,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full,
  output logic [CNT_W-1:0] o_nEntries
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
  assign do_pop  = i_pop && (count != '0);
  assign do_push = i_push && ((count != CNT_W'(DEPTH)) || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (i_cg) begin
      if (i_flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= next_ptr(wr_ptr);
        if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  generate
    if (FLOPS_NOT_MEM) begin : g_flops
      // NOTE: flop storage is reset so o_data is defined after reset; the RAM variant below is not.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (i_cg && do_push && !i_flush) begin
          mem[wr_ptr] <= i_data;
        end
      end
    end else begin : g_mem
      always_ff @(posedge i_clk) begin
        if (i_cg && do_push && !i_flush) mem[wr_ptr] <= i_data;
      end
    end
  endgenerate

  assign o_data     = mem[rd_ptr];
  assign o_empty    = (count == '0);
  assign o_full     = (count == CNT_W'(DEPTH));
  assign o_nEntries = count;

endmodule

// File: rtl/fifo_reader.sv
// Burst consumer: pops i_len words from an upstream show-ahead FIFO and
// re-presents them on a valid/ready stream through a two-entry buffer.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cg,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_aborted,
  output logic [LEN_W-1:0] o_remaining,
  output logic             o_pop,
  input  logic             i_empty,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
);

  state_e               state_q;
  state_e               state_d;
  logic [LEN_W-1:0]     remaining_q;
  logic [LEN_W-1:0]     remaining_d;
  logic                 aborted_q;
  logic                 aborted_d;
  logic [BUF_CNT_W-1:0] buf_entries;
  logic                 buf_empty;
  logic                 buf_full;
  logic                 buf_pop;
  logic                 abort_hit;

  // Abort is only meaningful while a burst is in flight.
  assign abort_hit = i_abort && (state_q != ST_IDLE);

  // Pop decision depends only on local state and the upstream flag, never on i_ready.
  assign o_pop = i_cg && (state_q == ST_BURST) && !i_empty &&
                 (remaining_q != '0) && (buf_entries < BUF_CNT_W'(BUF_DEPTH)) &&
                 !abort_hit;

  assign buf_pop = o_valid && i_ready && i_cg;

  fifo #(
    .WIDTH         (WIDTH),
    .DEPTH         (BUF_DEPTH),
    .FLOPS_NOT_MEM (1'b1)
  ) u_out_buf (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_cg       (i_cg),
    .i_flush    (abort_hit),
    .i_push     (o_pop),
    .i_data     (i_data),
    .i_pop      (buf_pop),
    .o_data     (o_data),
    .o_empty    (buf_empty),
    .o_full     (buf_full),
    .o_nEntries (buf_entries)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    remaining_d = remaining_q;
    aborted_d   = 1'b0;
    if (abort_hit) begin
      state_d     = ST_IDLE;
      remaining_d = '0;
      aborted_d   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            if (i_len != '0) begin
              state_d     = ST_BURST;
              remaining_d = i_len;
            end else begin
              state_d = ST_FINISH;
            end
          end
        end
        ST_BURST: begin
          if (o_pop) begin
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == LEN_W'(1)) state_d = ST_FLUSH_OUT;
          end
        end
        ST_FLUSH_OUT: begin
          // Leave once the buffer drains; no pushes can happen in this state.
          if ((buf_entries == '0) || ((buf_entries == BUF_CNT_W'(1)) && buf_pop))
            state_d = ST_FINISH;
        end
        ST_FINISH: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      aborted_q   <= 1'b0;
    end else if (i_cg) begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      aborted_q   <= aborted_d;
    end
  end

  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = (state_q == ST_FINISH);
  assign o_aborted   = aborted_q;
  assign o_remaining = remaining_q;
  assign o_valid     = !buf_empty;

  a_no_wrap: assert property (@(posedge i_clk) disable iff (i_rst)
    o_pop |-> (remaining_q != '0));

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    o_pop |-> !buf_full);

  a_pulses_exclusive: assert property (@(posedge i_clk) disable iff (i_rst)
    !(o_done && o_aborted));

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: directed scenarios plus randomized bursts
// checked against a queue-based model of the upstream FIFO and expected stream.
module tb_fifo_reader;
  localparam int WIDTH = 8;
  localparam int LEN_W = 8;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_cg;
  logic             i_start;
  logic [LEN_W-1:0] i_len;
  logic             i_abort;
  logic             i_empty;
  logic [WIDTH-1:0] i_data;
  logic             i_ready;
  logic             o_busy;
  logic             o_done;
  logic             o_aborted;
  logic [LEN_W-1:0] o_remaining;
  logic             o_pop;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;

  int checks   = 0;
  int failures = 0;
  int n_pops   = 0;
  logic starve = 1'b0;
  logic [WIDTH-1:0] up_q  [$];
  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] got_q [$];

  always #5 i_clk = ~i_clk;

  fifo_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_cg        (i_cg),
    .i_start     (i_start),
    .i_len       (i_len),
    .i_abort     (i_abort),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_aborted   (o_aborted),
    .o_remaining (o_remaining),
    .o_pop       (o_pop),
    .i_empty     (i_empty),
    .i_data      (i_data),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .i_ready     (i_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_up();
    i_empty = starve || (up_q.size() == 0);
    i_data  = (up_q.size() != 0) ? up_q[0] : '0;
  endtask

  // One clock: sample pre-edge pop/handshake, advance, then update the upstream and sink models.
  task automatic step();
    logic             pop_s;
    logic             hs_s;
    logic [WIDTH-1:0] d_s;
    #1;
    pop_s = o_pop;
    hs_s  = o_valid && i_ready && i_cg;
    d_s   = o_data;
    @(posedge i_clk);
    #1;
    if (pop_s) begin
      n_pops++;
      if (up_q.size() != 0) void'(up_q.pop_front());
    end
    if (hs_s) got_q.push_back(d_s);
    drive_up();
  endtask

  task automatic load(input int n);
    up_q.delete();
    exp_q.delete();
    got_q.delete();
    n_pops = 0;
    starve = 1'b0;
    for (int i = 0; i < n; i++) up_q.push_back(WIDTH'($urandom));
    drive_up();
  endtask

  task automatic expect_first(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(up_q[i]);
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      #1;
      seen = o_done;
    end
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check({tag, "_word"}, (i < got_q.size()) ? 32'(got_q[i]) : 32'hxxxx_xxxx, 32'(exp_q[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit         seen;
    logic [8:0] pop_m, valid_m, done_m, busy_m;
    int         busy_cnt;

    i_rst = 1'b1; i_cg = 1'b1; i_start = 1'b0; i_len = '0; i_abort = 1'b0; i_ready = 1'b0;
    load(0);
    step(); step();
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_aborted", o_aborted, 0);
    check("rst_remaining", o_remaining, 0);
    check("rst_pop", o_pop, 0);
    check("rst_valid", o_valid, 0);
    i_rst = 1'b0;
    step();

    // Basic burst of 4 from a preloaded upstream of 5 words.
    load(0);
    for (int i = 0; i < 5; i++) up_q.push_back(WIDTH'(8'h11 * (i + 1)));
    expect_first(4);
    drive_up();
    i_ready = 1'b1; i_len = 8'd4; i_start = 1'b1;
    pop_m = '0; valid_m = '0; done_m = '0; busy_m = '0;
    for (int c = 0; c < 9; c++) begin
      #1;
      pop_m[c] = o_pop; valid_m[c] = o_valid; done_m[c] = o_done; busy_m[c] = o_busy;
      step();
      i_start = 1'b0;
    end
    check("basic_pop_cycles", 32'(pop_m), 32'b0_0001_1110);
    check("basic_valid_cycles", 32'(valid_m), 32'b0_0011_1100);
    check("basic_done_cycles", 32'(done_m), 32'b0_0100_0000);
    check("basic_busy_cycles", 32'(busy_m), 32'b0_0111_1110);
    check_stream("basic");
    check("basic_left_count", up_q.size(), 1);
    check("basic_left_word", 32'((up_q.size() != 0) ? up_q[0] : 8'h00), 32'h55);

    // Backpressure: downstream stalls for 5 cycles.
    load(3);
    expect_first(3);
    i_ready = 1'b0; i_len = 8'd3; i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      if (c >= 2) check("bp_hold_data", 32'(o_data), 32'(exp_q[0]));
      if (c < 5) step();
    end
    check("bp_pops_stalled", n_pops, 2);
    check("bp_valid_stalled", o_valid, 1);
    i_ready = 1'b1;
    wait_done(30, seen);
    check("bp_done_seen", seen, 1);
    check_stream("bp");
    check("bp_pops_total", n_pops, 3);
    step();

    // Starved upstream for 10 cycles.
    load(2);
    expect_first(2);
    starve = 1'b1;
    drive_up();
    i_ready = 1'b1; i_len = 8'd2; i_start = 1'b1;
    step();
    i_start = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (o_busy) busy_cnt++;
      step();
    end
    check("starve_pops", n_pops, 0);
    check("starve_busy", busy_cnt, 10);
    starve = 1'b0;
    drive_up();
    wait_done(30, seen);
    check("starve_done_seen", seen, 1);
    check_stream("starve");
    step();

    // Zero-length start.
    load(1);
    i_len = 8'd0; i_start = 1'b1;
    step();
    i_start = 1'b0;
    #1;
    check("zero_done", o_done, 1);
    check("zero_busy", o_busy, 1);
    step();
    #1;
    check("zero_done_clear", o_done, 0);
    check("zero_pops", n_pops, 0);
    check("zero_left", up_q.size(), 1);

    // A start during a burst and during FINISH is ignored.
    load(3);
    expect_first(3);
    starve = 1'b1;
    drive_up();
    i_len = 8'd3; i_start = 1'b1;
    step();
    i_start = 1'b0;
    step(); step();
    i_len = 8'd7; i_start = 1'b1;
    step();
    i_start = 1'b0;
    #1;
    check("ign_start_remaining", o_remaining, 3);
    starve = 1'b0;
    drive_up();
    wait_done(30, seen);
    check("ign_done_seen", seen, 1);
    check_stream("ign");
    up_q.push_back(WIDTH'($urandom));
    up_q.push_back(WIDTH'($urandom));
    drive_up();
    i_len = 8'd2; i_start = 1'b1;
    step();
    i_start = 1'b0;
    #1;
    check("finish_start_busy", o_busy, 0);
    check("finish_start_remaining", o_remaining, 0);
    step();
    check("finish_start_no_pop", up_q.size(), 2);

    // Abort after 2 of 6 pops, one word delivered and one buffered.
    load(6);
    i_ready = 1'b0; i_len = 8'd6; i_start = 1'b1;
    step();
    i_start = 1'b0;
    step();
    i_ready = 1'b1;
    step();
    i_ready = 1'b0; i_abort = 1'b1;
    #1;
    check("abort_cycle_pop", o_pop, 0);
    check("abort_pre_remaining", o_remaining, 4);
    step();
    i_abort = 1'b0;
    #1;
    check("abort_valid", o_valid, 0);
    check("abort_remaining", o_remaining, 0);
    check("abort_pulse", o_aborted, 1);
    check("abort_no_done", o_done, 0);
    check("abort_busy", o_busy, 0);
    step();
    #1;
    check("abort_pulse_clear", o_aborted, 0);
    check("abort_pops", n_pops, 2);
    check("abort_delivered", got_q.size(), 1);
    got_q.delete();
    n_pops = 0;
    expect_first(1);
    i_ready = 1'b1; i_len = 8'd1; i_start = 1'b1;
    step();
    i_start = 1'b0;
    wait_done(30, seen);
    check("post_abort_done_seen", seen, 1);
    check_stream("post_abort");
    step();

    // Clock gate held low mid-burst, then reset mid-burst.
    load(6);
    expect_first(6);
    i_ready = 1'b1; i_len = 8'd6; i_start = 1'b1;
    step();
    i_start = 1'b0;
    step(); step();
    i_cg = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("cg_pop", o_pop, 0);
      check("cg_busy", o_busy, 1);
      check("cg_remaining", o_remaining, 4);
      check("cg_valid", o_valid, 1);
      check("cg_data", 32'(o_data), 32'(exp_q[1]));
      check("cg_done", o_done, 0);
      step();
    end
    i_cg = 1'b1;
    step();
    i_rst = 1'b1;
    step();
    #1;
    check("midrst_busy", o_busy, 0);
    check("midrst_done", o_done, 0);
    check("midrst_aborted", o_aborted, 0);
    check("midrst_remaining", o_remaining, 0);
    check("midrst_pop", o_pop, 0);
    check("midrst_valid", o_valid, 0);
    i_rst = 1'b0;
    step();

    // Randomized bursts with random backpressure, starvation and clock gating.
    for (int t = 0; t < 25; t++) begin
      int len;
      int extra;
      len   = $urandom_range(1, 8);
      extra = $urandom_range(0, 2);
      load(len + extra);
      expect_first(len);
      i_cg = 1'b1; i_ready = 1'($urandom_range(0, 1)); i_len = LEN_W'(len); i_start = 1'b1;
      step();
      i_start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 300 && !seen; c++) begin
        i_ready = ($urandom_range(0, 3) != 0);
        i_cg    = ($urandom_range(0, 7) != 0);
        starve  = ($urandom_range(0, 3) == 0);
        drive_up();
        #1;
        check("rnd_remaining", 32'(o_remaining), 32'(len - n_pops));
        check("rnd_valid", o_valid, 32'(n_pops > got_q.size()));
        if (o_valid)
          check("rnd_data", 32'(o_data),
                (got_q.size() < exp_q.size()) ? 32'(exp_q[got_q.size()]) : 32'hxxxx_xxxx);
        seen = o_done;
        if (!seen) step();
      end
      check("rnd_done_seen", seen, 1);
      i_cg = 1'b1;
      starve = 1'b0;
      drive_up();
      step();
      #1;
      check("rnd_idle", o_busy, 0);
      check_stream("rnd");
      check("rnd_left", up_q.size(), extra);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
